// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file command sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package regfile_seq_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    OP_LDI  = 2'b00,
    OP_MOV  = 2'b01,
    OP_ADD  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDS  = 3'd1,
    RDSW = 3'd2,
    RDD  = 3'd3,
    RDDW = 3'd4,
    WB   = 3'd5
  } state_e;

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational 8-bit adder for the sequencer's ADD write-back value.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: a, b operands; sum modulo-256 result; cout carry-out (only when
// REGFILE_SEQ_CARRY_EN is defined).
module regfile_seq_alu
  import regfile_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
`ifdef REGFILE_SEQ_CARRY_EN
  ,
  output logic              cout
`endif
);

`ifdef REGFILE_SEQ_CARRY_EN
  logic [DATA_W:0] sum_wide;

  assign sum_wide = {1'b0, a} + {1'b0, b};
  assign sum      = sum_wide[DATA_W-1:0];
  assign cout     = sum_wide[DATA_W];
`else
  assign sum = a + b;
`endif

endmodule

// File: rtl/regfile_seq.sv
// Command sequencer driving an 8x8 register file: LDI, MOV and ADD as fixed read/write-back sequences.
// Latency: write-back cycle is 1 (LDI), 3 (MOV) or 5 (ADD) cycles after the accept edge.
// Backpressure: cmd_ready is high only when idle and out of reset; one command in flight at a time.
// Ports: clk, rst (sync, active-high); cmd_valid/cmd_ready handshake with cmd_op/rd/rs/imm;
// n/d/w drive the register file, q is its read data; res holds the last write-back value,
// done pulses in the write-back cycle; carry (only with REGFILE_SEQ_CARRY_EN) holds the last ADD carry.
module regfile_seq
  import regfile_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] n,
  output logic [DATA_W-1:0] d,
  output logic              w,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] res,
  output logic              done
`ifdef REGFILE_SEQ_CARRY_EN
  ,
  output logic              carry
`endif
);

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [ADDR_W-1:0]   rd_q, rs_q;
  logic [DATA_W-1:0]   imm_q, a_q, b_q, res_q;
  logic [DATA_W-1:0]   sum, wb_dat;
  logic                accept;

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign res       = res_q;

`ifdef REGFILE_SEQ_CARRY_EN
  logic cout, carry_q;

  assign carry = carry_q;

  regfile_seq_alu u_alu (
    .a    (a_q),
    .b    (b_q),
    .sum  (sum),
    .cout (cout)
  );
`else
  regfile_seq_alu u_alu (
    .a    (a_q),
    .b    (b_q),
    .sum  (sum)
  );
`endif

  // Next-state decode. cmd_op is only looked at on an accept edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op_e'(cmd_op))
            OP_LDI:         state_d = WB;
            OP_MOV, OP_ADD: state_d = RDS;
            default:        state_d = IDLE;
          endcase
        end
      end
      RDS:     state_d = RDSW;
      RDSW:    state_d = (op_q == OP_ADD) ? RDD : WB;
      RDD:     state_d = RDDW;
      RDDW:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write-back value selected from latched operands only.
  always_comb begin
    wb_dat = '0;
    case (op_q)
      OP_LDI:  wb_dat = imm_q;
      OP_MOV:  wb_dat = b_q;
      OP_ADD:  wb_dat = sum;
      default: wb_dat = '0;
    endcase
  end

  // Register-file port decode from registered state; each read address is
  // held for two cycles so a registered-read file also returns valid data.
  always_comb begin
    n    = '0;
    d    = '0;
    w    = 1'b0;
    done = 1'b0;
    case (state_q)
      RDS, RDSW: n = rs_q;
      RDD, RDDW: n = rd_q;
      WB: begin
        n    = rd_q;
        d    = wb_dat;
        w    = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_LDI;
      rd_q    <= '0;
      rs_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
`ifdef REGFILE_SEQ_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op_e'(cmd_op);
        rd_q  <= cmd_rd;
        rs_q  <= cmd_rs;
        imm_q <= cmd_imm;
      end
      if (state_q == RDSW) b_q <= q;
      if (state_q == RDDW) a_q <= q;
      if (state_q == WB) begin
        res_q <= wb_dat;
`ifdef REGFILE_SEQ_CARRY_EN
        if (op_q == OP_ADD) carry_q <= cout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_seq.sv
// Directed self-checking bench for regfile_seq with a behavioural 8x8 register file.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_regfile_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_rd, cmd_rs;
  logic [7:0] cmd_imm;
  logic [2:0] n;
  logic [7:0] d, q, res;
  logic       w, done;
`ifdef REGFILE_SEQ_CARRY_EN
  logic       carry;
`endif

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int wr_mark;
  logic [7:0] rf [8];

  always #5 clk = ~clk;

  regfile_seq dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs    (cmd_rs),
    .cmd_imm   (cmd_imm),
    .n         (n),
    .d         (d),
    .w         (w),
    .q         (q),
    .res       (res),
    .done      (done)
`ifdef REGFILE_SEQ_CARRY_EN
    ,
    .carry     (carry)
`endif
  );

  // Register file: combinational read, synchronous write, own sync reset.
  assign q = rf[n];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else if (w) begin
      rf[n]  <= d;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command for one edge, then drive X onto the command fields.
  task automatic issue(input logic [1:0] op, input logic [2:0] rd,
                       input logic [2:0] rs, input logic [7:0] imm);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs    = rs;
    cmd_imm   = imm;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 'x;
    cmd_rd    = 'x;
    cmd_rs    = 'x;
    cmd_imm   = 'x;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_rd    = 3'd0;
    cmd_rs    = 3'd0;
    cmd_imm   = 8'h00;

    // Reset state
    tick();
    tick();
    chk("rst_ready", cmd_ready, 0);
    chk("rst_n", n, 0);
    chk("rst_d", d, 0);
    chk("rst_w", w, 0);
    chk("rst_done", done, 0);
    chk("rst_res", res, 0);
`ifdef REGFILE_SEQ_CARRY_EN
    chk("rst_carry", carry, 0);
`endif
    rst = 1'b0;
    #1;
    chk("ready_after_rst", cmd_ready, 1);

    // LDI r1 = FF: write-back in cycle 1, ready in cycle 2
    issue(2'b00, 3'd1, 3'd0, 8'hFF);
    chk("ldi_n", n, 1);
    chk("ldi_d", d, 8'hFF);
    chk("ldi_w", w, 1);
    chk("ldi_done", done, 1);
    chk("ldi_busy", cmd_ready, 0);
    tick();
    chk("ldi_res", res, 8'hFF);
    chk("ldi_ready", cmd_ready, 1);
    chk("ldi_w_off", w, 0);
    chk("ldi_done_off", done, 0);

    // LDI r1 = 5A, then MOV r4 <- r1
    issue(2'b00, 3'd1, 3'd0, 8'h5A);
    tick();
    issue(2'b01, 3'd4, 3'd1, 8'h00);
    chk("mov_c1_n", n, 1);
    chk("mov_c1_w", w, 0);
    tick();
    chk("mov_c2_n", n, 1);
    chk("mov_c2_w", w, 0);
    tick();
    chk("mov_wb_n", n, 4);
    chk("mov_wb_d", d, 8'h5A);
    chk("mov_wb_w", w, 1);
    chk("mov_wb_done", done, 1);
    tick();
    chk("mov_res", res, 8'h5A);
    chk("mov_rf4", rf[4], 8'h5A);
    chk("mov_ready", cmd_ready, 1);

    // Back-to-back LDIs r2 = FF, r3 = 01
    issue(2'b00, 3'd2, 3'd0, 8'hFF);
    tick();
    chk("b2b_ready", cmd_ready, 1);
    issue(2'b00, 3'd3, 3'd0, 8'h01);
    chk("b2b_wb_n", n, 3);
    tick();

    // ADD r2 = r2 + r3 = FF + 01 wraps to 00
    issue(2'b10, 3'd2, 3'd3, 8'h00);
    chk("add_c1_n", n, 3);
    tick();
    chk("add_c2_n", n, 3);
    tick();
    chk("add_c3_n", n, 2);
    tick();
    chk("add_c4_n", n, 2);
    chk("add_c4_w", w, 0);
    tick();
    chk("add_wb_n", n, 2);
    chk("add_wb_d", d, 8'h00);
    chk("add_wb_w", w, 1);
    chk("add_wb_done", done, 1);
    tick();
    chk("add_res", res, 8'h00);
    chk("add_rf2", rf[2], 8'h00);
`ifdef REGFILE_SEQ_CARRY_EN
    chk("add_carry1", carry, 1);
`endif

    // LDI r5 = 01 leaves carry untouched
    issue(2'b00, 3'd5, 3'd0, 8'h01);
    tick();
`ifdef REGFILE_SEQ_CARRY_EN
    chk("ldi_keeps_carry", carry, 1);
`endif

    // Busy: ADD r5 = r5 + r5 (01+01) while an LDI r6 = 77 is held valid
    wr_mark   = wr_cnt;
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_rd    = 3'd5;
    cmd_rs    = 3'd5;
    cmd_imm   = 8'h00;
    tick();
    cmd_op    = 2'b00;
    cmd_rd    = 3'd6;
    cmd_imm   = 8'h77;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("busy_ready_c%0d", c), cmd_ready, 0);
      chk($sformatf("busy_w_c%0d", c), w, 0);
      tick();
    end
    chk("busy_wb_d", d, 8'h02);
    chk("busy_wb_w", w, 1);
    chk("busy_wb_ready", cmd_ready, 0);
    tick();
    chk("busy_one_write", wr_cnt - wr_mark, 1);
    chk("busy_res", res, 8'h02);
    chk("busy_ready_after", cmd_ready, 1);
`ifdef REGFILE_SEQ_CARRY_EN
    chk("add_carry0", carry, 0);
`endif
    tick();
    cmd_valid = 1'b0;
    chk("held_ldi_n", n, 6);
    chk("held_ldi_d", d, 8'h77);
    chk("held_ldi_w", w, 1);
    tick();

    // Reset during RDDW of an ADD
    wr_mark = wr_cnt;
    issue(2'b10, 3'd2, 3'd3, 8'h00);
    tick();
    tick();
    tick();
    chk("rddw_n", n, 2);
    rst = 1'b1;
    tick();
    chk("mid_rst_w", w, 0);
    chk("mid_rst_n", n, 0);
    chk("mid_rst_d", d, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_res", res, 0);
    chk("mid_rst_ready", cmd_ready, 0);
`ifdef REGFILE_SEQ_CARRY_EN
    chk("mid_rst_carry", carry, 0);
`endif
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", cmd_ready, 1);
    tick();
    tick();
    chk("post_rst_no_write", wr_cnt - wr_mark, 0);
    chk("post_rst_w", w, 0);

    // Reserved opcode: accepted, no write, ready again next cycle
    wr_mark = wr_cnt;
    issue(2'b11, 3'd7, 3'd1, 8'hAA);
    chk("rsvd_ready", cmd_ready, 1);
    chk("rsvd_w", w, 0);
    chk("rsvd_done", done, 0);
    tick();
    chk("rsvd_no_write", wr_cnt - wr_mark, 0);
    chk("rsvd_res", res, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
